enemy_laser: RTL and testbench

Enemy-side laser projectile: the block that drives the player ship's hit input and consumes its position outputs.
- Accepts a fire request from the enemy formation at a given pixel position.
- Drops the laser down the screen once per frame tick.
- Checks overlap against the player's left/right span and emits a one-cycle hit pulse.
- Enforces a post-shot cooldown and freezes while the game is paused.

---
 rtl/enemy_laser.sv | 130 +++++++++++++
 tb/tb_enemy_laser.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_laser.sv
`default_nettype none
// ============================================================================
// Module      : enemy_laser
// Description : Enemy laser projectile. Accepts a fire request, falls one step
//               per unpaused frame, registers a one-cycle hit pulse on contact
//               with the player ship, then waits out a cooldown before rearming.
// Revision    : 1.0 - initial release
// ============================================================================
module enemy_laser #(
    parameter logic [11:0] color_p         = {4'hE, 4'h2, 4'h2},
    parameter logic [9:0]  step_p          = 10'd4,
    parameter logic [9:0]  width_p         = 10'd4,
    parameter logic [9:0]  height_p        = 10'd12,
    parameter logic [9:0]  player_top_p    = 10'd440,
    parameter logic [9:0]  bottom_border_p = 10'd480,
    parameter logic [7:0]  cooldown_p      = 8'd30
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_i,
    input  logic       freeze_i,
    input  logic       fire_i,
    input  logic [9:0] fire_x_i,
    input  logic [9:0] fire_y_i,
    input  logic [9:0] player_left_i,
    input  logic [9:0] player_right_i,
    input  logic       player_alive_i,
    output logic       hit_o,
    output logic       active_o,
    output logic       ready_o,
    output logic [9:0] laser_x_o,
    output logic [9:0] laser_y_o,
    output logic [3:0] laser_red_o,
    output logic [3:0] laser_green_o,
    output logic [3:0] laser_blue_o
);

    localparam logic [2:0] c_ST_IDLE    = 3'b001;
    localparam logic [2:0] c_ST_FALLING = 3'b010;
    localparam logic [2:0] c_ST_COOL    = 3'b100;
    localparam logic [7:0] c_COOL_LAST  = cooldown_p - 8'd1;

    logic [2:0] state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] cnt_q, cnt_d;
    logic       hit_q, hit_d;

    logic       w_tick;
    logic [9:0] w_y_next;
    logic       w_overlap;
    logic       w_hit;
    logic       w_bottom;

    assign w_tick    = frame_i & ~freeze_i;
    assign w_y_next  = y_q + step_p;
    assign w_overlap = ((x_q + width_p) > player_left_i) && (x_q < player_right_i);
    assign w_hit     = ((w_y_next + height_p) >= player_top_p) && w_overlap && player_alive_i;
    assign w_bottom  = w_y_next >= (bottom_border_p - height_p);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (fire_i && !freeze_i) begin
                    x_d     = fire_x_i;
                    y_d     = fire_y_i;
                    state_d = c_ST_FALLING;
                end
            end
            c_ST_FALLING: begin
                // A hit takes priority over leaving the bottom on the same tick.
                if (w_tick) begin
                    if (w_hit) begin
                        hit_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = c_ST_COOL;
                    end else if (w_bottom) begin
                        cnt_d   = 8'd0;
                        state_d = c_ST_COOL;
                    end else begin
                        y_d = w_y_next;
                    end
                end
            end
            c_ST_COOL: begin
                if (cooldown_p == 8'd0) begin
                    state_d = c_ST_IDLE;
                end else if (w_tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == c_COOL_LAST) begin
                        state_d = c_ST_IDLE;
                    end
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= c_ST_IDLE;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            cnt_q   <= 8'd0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    assign hit_o         = hit_q;
    assign active_o      = (state_q == c_ST_FALLING);
    assign ready_o       = (state_q == c_ST_IDLE);
    assign laser_x_o     = x_q;
    assign laser_y_o     = y_q;
    assign laser_red_o   = color_p[11:8];
    assign laser_green_o = color_p[7:4];
    assign laser_blue_o  = color_p[3:0];

endmodule
`default_nettype wire

// File: tb/tb_enemy_laser.sv
`default_nettype none
// ============================================================================
// Module      : tb_enemy_laser
// Description : Scoreboard bench for enemy_laser: directed scenarios followed by
//               randomized traffic, checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_laser;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       frame_i = 1'b0;
    logic       freeze_i = 1'b0;
    logic       fire_i = 1'b0;
    logic [9:0] fire_x_i = 10'd0;
    logic [9:0] fire_y_i = 10'd0;
    logic [9:0] player_left_i = 10'd0;
    logic [9:0] player_right_i = 10'd0;
    logic       player_alive_i = 1'b1;
    logic       hit_o, active_o, ready_o;
    logic [9:0] laser_x_o, laser_y_o;
    logic [3:0] laser_red_o, laser_green_o, laser_blue_o;

    always #5 clk = ~clk;

    enemy_laser dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .frame_i        (frame_i),
        .freeze_i       (freeze_i),
        .fire_i         (fire_i),
        .fire_x_i       (fire_x_i),
        .fire_y_i       (fire_y_i),
        .player_left_i  (player_left_i),
        .player_right_i (player_right_i),
        .player_alive_i (player_alive_i),
        .hit_o          (hit_o),
        .active_o       (active_o),
        .ready_o        (ready_o),
        .laser_x_o      (laser_x_o),
        .laser_y_o      (laser_y_o),
        .laser_red_o    (laser_red_o),
        .laser_green_o  (laser_green_o),
        .laser_blue_o   (laser_blue_o)
    );

    typedef struct packed {
        logic       hit;
        logic       active;
        logic       ready;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hits_seen = 0;

    // Reference model: 0 = waiting, 1 = in flight, 2 = recharging.
    int m_mode = 0;
    int m_x = 0;
    int m_y = 0;
    int m_ticks = 0;
    bit m_hit = 1'b0;

    task automatic model_step();
        exp_t e;
        int   yn;
        bit   tick;
        tick  = frame_i && !freeze_i;
        m_hit = 1'b0;
        if (reset_i) begin
            m_mode = 0; m_x = 0; m_y = 0; m_ticks = 0;
        end else if (m_mode == 0) begin
            if (fire_i && !freeze_i) begin
                m_x = int'(fire_x_i); m_y = int'(fire_y_i); m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (tick) begin
                yn = m_y + 4;
                if (yn + 12 >= 440 && m_x + 4 > int'(player_left_i) &&
                    m_x < int'(player_right_i) && player_alive_i) begin
                    m_hit = 1'b1; m_mode = 2; m_ticks = 0;
                end else if (yn >= 480 - 12) begin
                    m_mode = 2; m_ticks = 0;
                end else begin
                    m_y = yn;
                end
            end
        end else begin
            if (tick) begin
                m_ticks++;
                if (m_ticks >= 30) m_mode = 0;
            end
        end
        e.hit    = m_hit;
        e.active = (m_mode == 1);
        e.ready  = (m_mode == 0);
        e.x      = 10'(m_x);
        e.y      = 10'(m_y);
        exp_q.push_back(e);
    endtask

    // Inputs change 2 time units after a rising edge; the model predicts the
    // outputs that the following rising edge will produce.
    task automatic drive(input bit rst, input bit frm, input bit frz, input bit fir,
                         input int fx, input int fy);
        @(posedge clk);
        #2;
        reset_i  = rst;
        frame_i  = frm;
        freeze_i = frz;
        fire_i   = fir;
        fire_x_i = 10'(fx);
        fire_y_i = 10'(fy);
        model_step();
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n, input bit frz);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, frz, 0, 0, 0);
            drive(0, 0, frz, 0, 0, 0);
        end
    endtask

    task automatic set_player(input int l, input int r, input bit alive);
        player_left_i  = 10'(l);
        player_right_i = 10'(r);
        player_alive_i = alive;
    endtask

    // Monitor: one prediction per rising edge, compared 1 unit after the edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {hit_o, active_o, ready_o, laser_x_o, laser_y_o};
                if (hit_o === 1'b1) hits_seen++;
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got hit=%b act=%b rdy=%b x=%0d y=%0d expected hit=%b act=%b rdy=%b x=%0d y=%0d",
                             $time, a.hit, a.active, a.ready, a.x, a.y,
                             e.hit, e.active, e.ready, e.x, e.y);
                end
            end
        end
    end

    initial begin
        int exp_hits;
        // Reset and colour constants.
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        quiet(2);
        checks++;
        if ({laser_red_o, laser_green_o, laser_blue_o} !== 12'hE22) begin
            failures++;
            $display("FAIL colour got %h expected e22", {laser_red_o, laser_green_o, laser_blue_o});
        end

        // Hit run with a freeze at y=200 and a rejected fire in flight.
        set_player(280, 320, 1'b1);
        drive(0, 0, 1, 1, 77, 77);       // fire while frozen: ignored
        drive(0, 0, 0, 1, 300, 100);
        quiet(1);
        ticks(25, 1'b0);
        ticks(10, 1'b1);
        drive(0, 0, 0, 1, 17, 33);
        ticks(57, 1'b0);
        // Cooldown with a stall and a rejected fire.
        ticks(5, 1'b0);
        ticks(5, 1'b1);
        drive(0, 0, 0, 1, 9, 9);
        ticks(24, 1'b0);
        drive(0, 1, 0, 0, 0, 0);
        // Fire on the very cycle ready returns; then a miss run.
        set_player(0, 40, 1'b1);
        drive(0, 0, 0, 1, 300, 100);
        ticks(95, 1'b0);
        ticks(31, 1'b0);

        // Dead player overlapping the laser: no hit, exits at the bottom.
        set_player(280, 320, 1'b0);
        drive(0, 0, 0, 1, 300, 100);
        ticks(95, 1'b0);
        ticks(31, 1'b0);

        // Reset mid-flight at y=200.
        set_player(280, 320, 1'b1);
        drive(0, 0, 0, 1, 300, 100);
        ticks(25, 1'b0);
        drive(1, 0, 0, 0, 0, 0);
        quiet(3);

        exp_hits = 1;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (hits_seen != exp_hits) begin
            failures++;
            $display("FAIL directed_hit_count got %0d expected %0d", hits_seen, exp_hits);
        end

        // Randomized traffic.
        for (int i = 0; i < 15000; i++) begin
            int l;
            if ($urandom_range(0, 199) == 0) begin
                l = $urandom_range(0, 600);
                set_player(l, l + $urandom_range(0, 39), $urandom_range(0, 9) != 0);
            end
            drive($urandom_range(0, 2999) == 0,
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 635),
                  $urandom_range(0, 467));
        end
        quiet(2);

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
